seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
// Avalon-MM slave that drives a 4-digit multiplexed common-anode seven-segment display.
// Holds a 16-bit hex value as 4 nibbles, digit0 = [3:0] rightmost, and scans the digits time-sliced.
// Features: per-frame tear-free update, 16-level PWM brightness, anti-ghost blanking, leading-zero blanking.
// Sits on the system bus next to the other PIO slaves and drives the front-panel display pins directly.
// PARAMETERS
// SLOT_CYCLES    5008  clk cycles a digit may be lit per slot; must be a multiple of 16
// BLANK_CYCLES   256   clk cycles all digits are dark before each slot (anti-ghost)
// SEG_ACTIVE_LOW 1     1: seg pins are inverted at the output
// DIG_ACTIVE_LOW 1     1: dig pins are inverted at the output
// PORTS
// clk         in   1   system clock
// reset_n     in   1   reset
// address     in   2   0=DATA 1=CTRL 2=STATUS(ro) 3=reserved (reads 0, writes ignored)
// chipselect  in   1   slave select
// write_n     in   1   active-low write strobe
// read_n      in   1   active-low read strobe
// writedata   in   16  write data
// readdata    out  16  read data, registered, read latency 1
// seg         out  8   [6:0]=segments g..a, [7]=dp
// dig         out  4   digit enables, bit i = digit i
// frame_sync  out  1   1-cycle pulse at the start of each frame
// BEHAVIOUR
// - Reset is reset_n, asynchronous, active-low; clock is clk. All outputs and the state below are registered.
// - Reset values: readdata=0, frame_sync=0, seg/dig at inactive level (all pins high when ACTIVE_LOW=1).
//   Also at reset: active=pending=0, pend_flag=0, CTRL=16'hFF01.
// - CTRL fields: [0]=enable, [1]=lz_blank, [7:4]=dp mask, [11:8]=digit enable mask, [15:12]=brightness.
// - DATA write: pending<=writedata and pend_flag<=1. DATA read returns pending.
//   STATUS read returns {13'b0, cur_digit[1:0], pend_flag}.
// - Frame boundary = entry into BLANK of digit0. If pend_flag=1: active<=pending and pend_flag<=0.
//   A DATA write in the same cycle as the boundary: active takes the pre-write pending value,
//   pending takes writedata, and pend_flag stays 1.
// - FSM states:
//   IDLE: enable=0; all pins inactive, counters cleared.
//   BLANK: BLANK_CYCLES, all digits dark.
//   ON: on_cycles.
//   REST: SLOT_CYCLES-on_cycles; skipped when this is 0.
// - Transitions: IDLE->BLANK(d0) the cycle after enable=1. REST (or ON when REST is empty) -> BLANK(d+1 mod 4).
//   enable=0 in any state -> IDLE on the next cycle, with outputs inactive in that cycle.
// - on_cycles = (brightness+1)*(SLOT_CYCLES/16). Compute it in a counter wide enough for SLOT_CYCLES; it is never 0.
//   Sample brightness at BLANK entry so a mid-slot CTRL write cannot truncate a slot.
// - The seg pattern for the next digit is loaded at BLANK entry. dig asserts only in ON, one-hot on cur_digit.
// - A digit is dark (dig inactive for the whole slot) if its mask bit is 0.
//   A digit is also dark if lz_blank=1, the digit is digit 3..1, and that nibble and every more-significant nibble are 0.
//   Digit0 is never LZ-blanked. A dark digit still consumes its full slot.
// - dp = dp mask bit of the current digit. seg encoding is internal active-high, with the
//   inversion parameters applied at the pins.
// - frame_sync pulses with BLANK(d0) entry, including the first entry after IDLE.
// - Frame period = 4*(BLANK_CYCLES+SLOT_CYCLES) clk cycles.
// STRUCTURE
// - seven_seg_pkg: register addresses, CTRL bit positions, CTRL reset value, FSM state encoding, hex->segment table.
// - One sub-module, seven_seg_hex_decode: nibble -> 7-bit active-high pattern, 0->7'h3F ... F->7'h71.
// - Top level holds the Avalon decode, the shadow/active registers, the FSM plus slot counter, and output inversion.
// TESTING (bench params SLOT_CYCLES=32, BLANK_CYCLES=4, both ACTIVE_LOW=1; frame=144 cycles)
// - Reset, then release: seg=8'hFF and dig=4'hF during reset. First frame_sync comes 1 cycle after release.
//   Digit0 then lights with seg=8'hC0 ('0') for 32 cycles after 4 dark cycles.
// - Write DATA=16'h1234 mid-frame: STATUS[0]=1 until the next frame_sync, and old digits persist until then.
//   Next frame: d0 seg=8'h99 ('4'), d1 8'hB0, d2 8'hA4, d3 8'hF9.
// - CTRL brightness=0: each dig low for exactly 2 cycles per 36-cycle slot. Brightness=F: low 32 cycles.
//   Write brightness mid-ON: the current slot is unchanged.
// - DATA=16'h0050 with CTRL lz_blank=1: d3 and d2 stay dark. d1 shows 8'h92 ('5'), d0 shows 8'hC0.
//   Repeat with dp mask=4'b0010: d1 seg=8'h12.
// - Clear enable during the d2 ON state: the next cycle gives dig=4'hF and seg=8'hFF.
//   Set enable again: frame_sync one cycle later, scan restarts at d0.
// - DATA write coinciding with the frame boundary: active takes the old pending value, STATUS[0] stays 1,
//   and the new value is displayed one frame later. Also apply reset_n low mid-ON: outputs are inactive immediately.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: register map,
// CTRL field positions, scan FSM encoding and the hex-to-segment table.
package seven_seg_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_LZ         = 1;
    localparam int CTRL_DP_LSB     = 4;
    localparam int CTRL_MASK_LSB   = 8;
    localparam int CTRL_BRIGHT_LSB = 12;

    localparam logic [15:0] CTRL_RESET = 16'hFF01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2,
        ST_REST  = 2'd3
    } scan_state_e;

    // Segment order is g..a in bits [6:0], active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Nibble to active-high seven-segment pattern (g..a).
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Avalon-MM slave scanning a 4-digit multiplexed seven-segment display with
// frame-synchronous data update, PWM brightness, anti-ghost blanking and LZ blanking.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int SLOT_CYCLES    = 5008,
    parameter int BLANK_CYCLES   = 256,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic        frame_sync
);

    localparam int CNT_MAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SLOT_LEN   = CNT_W'(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_UNIT  = CNT_W'(SLOT_CYCLES / 16);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] on_len_q, on_len_d;
    logic [1:0]       digit_q, digit_d;
    logic             lit_q, lit_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       dig_q, dig_d;
    logic             frame_sync_q, frame_sync_d;
    logic [15:0]      ctrl_q, ctrl_d;
    logic [15:0]      pending_q, pending_d;
    logic [15:0]      active_q, active_d;
    logic             pend_flag_q, pend_flag_d;
    logic [15:0]      readdata_q, readdata_d;

    logic             blank_entry;
    logic             wr_en, rd_en;
    logic [3:0]       nibble_sel;
    logic [6:0]       hex_seg;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    // Scan sequencing: BLANK -> ON -> REST per digit, REST skipped at full brightness.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        digit_d      = digit_q;
        blank_entry  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                digit_d = 2'd0;
                if (ctrl_q[CTRL_EN]) begin
                    state_d     = ST_BLANK;
                    blank_entry = 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (cnt_q == on_len_q - CNT_ONE) begin
                    cnt_d = '0;
                    if (on_len_q == SLOT_LEN) begin
                        state_d     = ST_BLANK;
                        digit_d     = digit_q + 2'd1;
                        blank_entry = 1'b1;
                    end else begin
                        state_d = ST_REST;
                    end
                end
            end
            default: begin
                if (cnt_q == SLOT_LEN - on_len_q - CNT_ONE) begin
                    cnt_d       = '0;
                    state_d     = ST_BLANK;
                    digit_d     = digit_q + 2'd1;
                    blank_entry = 1'b1;
                end
            end
        endcase
        if (!ctrl_q[CTRL_EN]) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            digit_d     = 2'd0;
            blank_entry = 1'b0;
        end
        frame_sync_d = blank_entry && (digit_d == 2'd0);
    end

    // Bus side: the shadow DATA value is promoted to the displayed value only at a frame boundary.
    always_comb begin
        ctrl_d      = ctrl_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        active_d    = active_q;
        readdata_d  = readdata_q;
        if (frame_sync_d && pend_flag_q) begin
            active_d    = pending_q;
            pend_flag_d = 1'b0;
        end
        if (wr_en && address == ADDR_DATA) begin
            pending_d   = writedata;
            pend_flag_d = 1'b1;
        end
        if (wr_en && address == ADDR_CTRL) begin
            ctrl_d = writedata;
        end
        if (rd_en) begin
            case (address)
                ADDR_DATA:   readdata_d = pending_q;
                ADDR_CTRL:   readdata_d = ctrl_q;
                ADDR_STATUS: readdata_d = {13'b0, digit_q, pend_flag_q};
                default:     readdata_d = 16'h0000;
            endcase
        end
    end

    assign nibble_sel = active_d[{digit_d, 2'b00} +: 4];

    seven_seg_hex_decode u_hex_decode (
        .nibble (nibble_sel),
        .seg    (hex_seg)
    );

    // Per-slot attributes are frozen at BLANK entry so CTRL writes only affect later slots.
    always_comb begin
        on_len_d = on_len_q;
        lit_d    = lit_q;
        seg_d    = seg_q;
        if (state_d == ST_IDLE) begin
            seg_d = 8'h00;
            lit_d = 1'b0;
        end else if (blank_entry) begin
            on_len_d = (CNT_W'(ctrl_q[CTRL_BRIGHT_LSB +: 4]) + CNT_ONE) * SLOT_UNIT;
            seg_d    = {ctrl_q[CTRL_DP_LSB + 32'(digit_d)], hex_seg};
            lit_d    = ctrl_q[CTRL_MASK_LSB + 32'(digit_d)] &&
                       !(ctrl_q[CTRL_LZ] && digit_d != 2'd0 &&
                         (active_d >> {digit_d, 2'b00}) == 16'h0000);
        end
        dig_d = (state_d == ST_ON && lit_q) ? (4'b0001 << digit_q) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            on_len_q     <= '0;
            digit_q      <= 2'd0;
            lit_q        <= 1'b0;
            seg_q        <= 8'h00;
            dig_q        <= 4'h0;
            frame_sync_q <= 1'b0;
            ctrl_q       <= CTRL_RESET;
            pending_q    <= 16'h0000;
            active_q     <= 16'h0000;
            pend_flag_q  <= 1'b0;
            readdata_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            on_len_q     <= on_len_d;
            digit_q      <= digit_d;
            lit_q        <= lit_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_sync_q <= frame_sync_d;
            ctrl_q       <= ctrl_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            pend_flag_q  <= pend_flag_d;
            readdata_q   <= readdata_d;
        end
    end

    assign seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dig        = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
    assign frame_sync = frame_sync_q;
    assign readdata   = readdata_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: directed steps plus random bus traffic, compared each cycle
// against a frame-position model of the display scan.
module tb_seven_seg_scan_ctrl;

    localparam int S      = 32;
    localparam int B      = 4;
    localparam int SLOT_T = S + B;
    localparam int FRAME  = 4 * SLOT_T;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [15:0] writedata = 16'h0000;
    logic [15:0] readdata;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame_sync;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_ctrl #(
        .SLOT_CYCLES    (S),
        .BLANK_CYCLES   (B),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg        (seg),
        .dig        (dig),
        .frame_sync (frame_sync)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: scan position within a frame, plus the register values the bus sees.
    bit          m_run, m_pflag, m_lit, m_fs;
    int          m_pos, m_on;
    logic [15:0] m_ctrl, m_pend, m_act, m_rd;
    logic [7:0]  m_seg;

    task automatic model_reset();
        m_run = 0; m_pflag = 0; m_lit = 0; m_fs = 0; m_pos = 0; m_on = 0;
        m_ctrl = 16'hFF01; m_pend = 16'h0; m_act = 16'h0; m_rd = 16'h0; m_seg = 8'h0;
    endtask

    function automatic logic [3:0] exp_dig();
        int off;
        off = m_pos % SLOT_T;
        if (m_run && m_lit && off >= B && off < B + m_on) return 4'b0001 << (m_pos / SLOT_T);
        return 4'b0000;
    endfunction

    task automatic model_step();
        bit boundary;
        int d;
        logic [1:0] cur;
        cur = m_run ? 2'(m_pos / SLOT_T) : 2'd0;
        if (chipselect && !read_n) begin
            case (address)
                2'd0: m_rd = m_pend;
                2'd1: m_rd = m_ctrl;
                2'd2: m_rd = {13'b0, cur, m_pflag};
                default: m_rd = 16'h0;
            endcase
        end
        boundary = 0;
        if (!m_ctrl[0]) m_run = 0;
        else if (!m_run) begin m_run = 1; m_pos = 0; boundary = 1; end
        else begin m_pos = (m_pos + 1) % FRAME; boundary = (m_pos % SLOT_T) == 0; end
        m_fs = m_run && boundary && m_pos == 0;
        if (m_run && boundary) begin
            d = m_pos / SLOT_T;
            if (d == 0 && m_pflag) begin m_act = m_pend; m_pflag = 0; end
            m_on  = (int'(m_ctrl[15:12]) + 1) * (S / 16);
            m_seg = {m_ctrl[4 + d], seg_tab[(m_act >> (4 * d)) & 16'hF]};
            m_lit = m_ctrl[8 + d] && !(m_ctrl[1] && d != 0 && (m_act >> (4 * d)) == 16'h0);
        end
        if (!m_run) begin m_seg = 8'h0; m_lit = 0; end
        if (chipselect && !write_n) begin
            if (address == 2'd0) begin m_pend = writedata; m_pflag = 1; end
            if (address == 2'd1) m_ctrl = writedata;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("seg", {8'h0, seg}, {8'h0, ~m_seg});
        check("dig", {12'h0, dig}, {12'h0, ~exp_dig()});
        check("frame_sync", {15'h0, frame_sync}, {15'h0, m_fs});
        check("readdata", readdata, m_rd);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        chipselect = 1; write_n = 0; address = a; writedata = d;
        tick();
        chipselect = 0; write_n = 1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1; read_n = 0; address = a;
        tick();
        chipselect = 0; read_n = 1;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            if (m_run && m_pos == p) return;
        end
        checks++; errors++;
        $error("FAIL wait_pos observed=timeout expected=pos %0d", p);
    endtask

    task automatic count_frame(output int lit);
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (dig !== 4'hF) lit++;
            tick();
        end
    endtask

    int lit_cnt;

    initial begin
        model_reset();
        #12;
        check("reset_seg", {8'h0, seg}, 16'h00FF);
        check("reset_dig", {12'h0, dig}, 16'h000F);
        check("reset_rd", readdata, 16'h0000);
        @(negedge clk) reset_n = 1;
        tick();
        check("first_fs", {15'h0, frame_sync}, 16'h0001);
        for (int i = 0; i < B; i++) tick();
        check("d0_seg", {8'h0, seg}, 16'h00C0);
        check("d0_dig", {12'h0, dig}, 16'h000E);

        // Tear-free DATA update
        wait_pos(60);
        bus_write(2'd0, 16'h1234);
        bus_read(2'd2);
        check("pend_flag_set", {15'h0, readdata[0]}, 16'h0001);
        wait_pos(B);
        check("d0_seg_4", {8'h0, seg}, 16'h0099);
        bus_read(2'd2);
        check("pend_flag_clr", {15'h0, readdata[0]}, 16'h0000);
        wait_pos(SLOT_T + B);
        check("d1_seg_3", {8'h0, seg}, 16'h00B0);

        // Brightness
        bus_write(2'd1, 16'h0F01);
        wait_pos(0);
        count_frame(lit_cnt);
        check("bright0_lit", 16'(lit_cnt), 16'd8);
        bus_write(2'd1, 16'hFF01);
        wait_pos(0);
        count_frame(lit_cnt);
        check("brightF_lit", 16'(lit_cnt), 16'd128);
        wait_pos(B + 3);
        bus_write(2'd1, 16'h0F01);
        wait_pos(B + 31);
        check("midon_dig", {12'h0, dig}, 16'h000E);
        bus_write(2'd1, 16'hFF01);

        // Leading-zero blanking and dp
        bus_write(2'd1, 16'hFF03);
        bus_write(2'd0, 16'h0050);
        wait_pos(0);
        count_frame(lit_cnt);
        check("lz_lit", 16'(lit_cnt), 16'd64);
        bus_write(2'd1, 16'hFF23);
        wait_pos(SLOT_T + B);
        check("dp_seg", {8'h0, seg}, 16'h0012);
        check("dp_dig", {12'h0, dig}, 16'h000D);
        bus_write(2'd1, 16'hFF01);

        // Disable during d2 ON, then re-enable
        wait_pos(2 * SLOT_T + B + 5);
        check("d2_on", {12'h0, dig}, 16'h000B);
        bus_write(2'd1, 16'hFF00);
        tick();
        check("dis_dig", {12'h0, dig}, 16'h000F);
        check("dis_seg", {8'h0, seg}, 16'h00FF);
        for (int i = 0; i < 5; i++) tick();
        bus_write(2'd1, 16'hFF01);
        tick();
        check("reen_fs", {15'h0, frame_sync}, 16'h0001);

        // DATA write landing on the frame boundary
        wait_pos(50);
        bus_write(2'd0, 16'hABCD);
        wait_pos(FRAME - 1);
        bus_write(2'd0, 16'h5678);
        check("bnd_fs", {15'h0, frame_sync}, 16'h0001);
        bus_read(2'd2);
        check("bnd_flag", {15'h0, readdata[0]}, 16'h0001);
        wait_pos(B);
        check("bnd_old", {8'h0, seg}, 16'h00A1);
        wait_pos(B);
        check("bnd_new", {8'h0, seg}, 16'h0080);

        // Random bus traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r == 0) bus_write(2'd0, 16'($urandom));
            else if (r == 1) bus_write(2'd1, {16'($urandom) & 16'hFFF2, 1'b0, ($urandom_range(0, 9) != 0)} );
            else if (r == 2) bus_write(2'(($urandom_range(2, 3))), 16'($urandom));
            else if (r < 5) bus_read(2'($urandom_range(0, 3)));
            else tick();
        end

        // Asynchronous reset mid-ON
        bus_write(2'd1, 16'hFF01);
        wait_pos(B + 2);
        reset_n = 0;
        #1;
        check("arst_seg", {8'h0, seg}, 16'h00FF);
        check("arst_dig", {12'h0, dig}, 16'h000F);
        check("arst_fs", {15'h0, frame_sync}, 16'h0000);
        model_reset();
        @(negedge clk) reset_n = 1;
        tick();
        check("arst_fs_after", {15'h0, frame_sync}, 16'h0001);
        for (int i = 0; i < 40; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
